// File: rtl/led_fader.sv
// led_fader: turns a raw on/off LED level into a PWM drive that ramps brightness
// linearly up or down on every transition. FREQ=0 or RAMP_MS=0 gives a plain follower.
module led_fader #(
  parameter int unsigned FREQ     = 0,
  parameter int unsigned RAMP_MS  = 0,
  parameter int unsigned PWM_BITS = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              led_i,
  output logic              led_o,
  output logic [PWM_BITS:0] level_o,
  output logic              busy_o,
  output logic [1:0]        state_o   // debug: OFF=0 RISE=1 ON=2 FALL=3
);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_RISE = 2'd1,
    S_ON   = 2'd2,
    S_FALL = 2'd3
  } state_t;

  localparam bit BYPASS = (FREQ == 0) || (RAMP_MS == 0);
  localparam logic [PWM_BITS:0] DUTY_MAX = {1'b1, {PWM_BITS{1'b0}}};

  // led_i comes from an unrelated timing domain as far as this block cares
  logic sync_q;
  logic led_s;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= 1'b0;
      led_s  <= 1'b0;
    end else begin
      sync_q <= led_i;
      led_s  <= sync_q;
    end
  end

  if (BYPASS) begin : g_bypass
    logic led_q;

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        led_q <= 1'b0;
      end else begin
        led_q <= led_s;
      end
    end

    assign led_o   = led_q;
    assign level_o = led_s ? DUTY_MAX : '0;
    assign busy_o  = 1'b0;
    assign state_o = led_s ? S_ON : S_OFF;

  end else begin : g_ramp
    localparam longint unsigned STEP_RAW =
      (64'(FREQ) * 64'(RAMP_MS)) / (64'd1000 << PWM_BITS);
    localparam longint unsigned STEP_CYCLES = (STEP_RAW == 64'd0) ? 64'd1 : STEP_RAW;
    localparam int TMR_W = (STEP_CYCLES > 64'd1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STEP_CYCLES - 64'd1);
    localparam logic [PWM_BITS:0] DUTY_ONE    = {{PWM_BITS{1'b0}}, 1'b1};
    localparam logic [PWM_BITS:0] DUTY_MAX_M1 = {1'b0, {PWM_BITS{1'b1}}};

    state_t              state_q, state_d;
    logic [PWM_BITS:0]   duty_q, duty_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic                tick;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS:0]   duty_latched_q;
    logic                led_q;

    assign tick = (tmr_q == TMR_LAST);

    // A level reversal always wins over reaching a bound: duty holds that cycle.
    always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      case (state_q)
        S_OFF: begin
          duty_d = '0;
          if (led_s) state_d = S_RISE;
        end
        S_RISE: begin
          if (!led_s) begin
            state_d = S_FALL;
          end else if (duty_q == DUTY_MAX) begin
            state_d = S_ON;
          end else if (tick) begin
            duty_d = duty_q + DUTY_ONE;
            if (duty_q == DUTY_MAX_M1) state_d = S_ON;
          end
        end
        S_ON: begin
          duty_d = DUTY_MAX;
          if (!led_s) state_d = S_FALL;
        end
        S_FALL: begin
          if (led_s) begin
            state_d = S_RISE;
          end else if (duty_q == '0) begin
            state_d = S_OFF;
          end else if (tick) begin
            duty_d = duty_q - DUTY_ONE;
            if (duty_q == DUTY_ONE) state_d = S_OFF;
          end
        end
        default: begin
          state_d = S_OFF;
          duty_d  = '0;
        end
      endcase
    end

    // Step timer restarts on every state entry so each ramp step is a full period.
    always_comb begin
      tmr_d = tmr_q + TMR_W'(1);
      if (tick) tmr_d = '0;
      if ((state_d != state_q) || (state_q == S_OFF) || (state_q == S_ON)) begin
        tmr_d = '0;
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        state_q <= S_OFF;
        duty_q  <= '0;
        tmr_q   <= '0;
      end else begin
        state_q <= state_d;
        duty_q  <= duty_d;
        tmr_q   <= tmr_d;
      end
    end

    // Duty is only picked up at the period boundary to avoid runt pulses.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        pwm_cnt_q      <= '0;
        duty_latched_q <= '0;
        led_q          <= 1'b0;
      end else begin
        pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
        if (pwm_cnt_q == '1) duty_latched_q <= duty_q;
        led_q <= ({1'b0, pwm_cnt_q} < duty_latched_q);
      end
    end

    assign led_o   = led_q;
    assign level_o = duty_q;
    assign busy_o  = (state_q == S_RISE) || (state_q == S_FALL);
    assign state_o = state_q;
  end

endmodule

// File: tb/tb_led_fader.sv
// Bench for led_fader: a ramping instance (4 cycles per step, 4-bit PWM) and a
// bypass instance share led_i/rst_ni; a reference model feeds expected queues.
module tb_led_fader;
  localparam int PB   = 4;
  localparam int MAXD = 16;
  localparam int STEP = 4;   // 1000 Hz * 64 ms / (1000 * 16)
  localparam int OFF = 0, RISE = 1, ON = 2, FALL = 3;

  logic clk = 1'b0;
  logic rst_ni;
  logic led_i;
  logic          led_o, busy_o;
  logic [PB:0]   level_o;
  logic [1:0]    state_o;
  logic          b_led_o, b_busy_o;
  logic [PB:0]   b_level_o;
  logic [1:0]    b_state_o;

  always #5 clk = ~clk;

  led_fader #(.FREQ(1000), .RAMP_MS(64), .PWM_BITS(PB)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .led_i(led_i),
    .led_o(led_o), .level_o(level_o), .busy_o(busy_o), .state_o(state_o)
  );

  led_fader #(.FREQ(0), .RAMP_MS(64), .PWM_BITS(PB)) dut_byp (
    .clk_i(clk), .rst_ni(rst_ni), .led_i(led_i),
    .led_o(b_led_o), .level_o(b_level_o), .busy_o(b_busy_o), .state_o(b_state_o)
  );

  typedef struct packed {
    logic [PB:0] level;
    logic        busy;
    logic [1:0]  state;
    logic        b_led;
    logic [PB:0] b_level;
  } exp_t;

  exp_t exp_q[$];
  int   pwm_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  int m_mode = OFF, m_base = 0, m_since = 0, m_duty = 0, m_edges = 0;
  logic [1:0] hist = 2'b00;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
  endtask

  // Reference: ramp duty = entry duty +/- (cycles since entry / STEP), saturating.
  always @(posedge clk) begin : ref_model
    exp_t e;
    logic ls, ls_lvl;
    ls     = hist[1];
    ls_lvl = hist[0];
    if (!rst_ni) begin
      m_mode = OFF; m_duty = 0; m_base = 0; m_since = 0; m_edges = 0;
      pwm_q = {};
      pwm_q.push_back(0);
      ls = 1'b0; ls_lvl = 1'b0;
      hist = 2'b00;
    end else begin
      m_edges++;
      if (m_edges % MAXD == 0) pwm_q.push_back(m_duty);
      case (m_mode)
        OFF: if (ls) begin m_mode = RISE; m_base = m_duty; m_since = 0; end
        RISE: begin
          if (!ls) begin m_mode = FALL; m_base = m_duty; m_since = 0; end
          else if (m_duty == MAXD) m_mode = ON;
          else begin
            m_since++;
            m_duty = m_base + m_since / STEP;
            if (m_duty >= MAXD) begin m_duty = MAXD; m_mode = ON; end
          end
        end
        ON: if (!ls) begin m_mode = FALL; m_base = MAXD; m_since = 0; end
        default: begin
          if (ls) begin m_mode = RISE; m_base = m_duty; m_since = 0; end
          else if (m_duty == 0) m_mode = OFF;
          else begin
            m_since++;
            m_duty = m_base - m_since / STEP;
            if (m_duty <= 0) begin m_duty = 0; m_mode = OFF; end
          end
        end
      endcase
      hist = {hist[0], led_i};
    end
    e.level   = m_duty[PB:0];
    e.busy    = (m_mode == RISE) || (m_mode == FALL);
    e.state   = m_mode[1:0];
    e.b_led   = ls;
    e.b_level = ls_lvl ? MAXD[PB:0] : '0;
    exp_q.push_back(e);
  end

  int acc = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk("level",    level_o,   e.level);
      chk("busy",     busy_o,    e.busy);
      chk("state",    state_o,   e.state);
      chk("byp_led",  b_led_o,   e.b_led);
      chk("byp_level", b_level_o, e.b_level);
      chk("byp_busy", b_busy_o,  0);
    end
    // PWM: high cycles per period must equal the duty captured at the period start
    if (m_edges == 0) begin
      acc = 0;
    end else begin
      acc += int'(led_o);
      if (m_edges % MAXD == 0) begin
        if (pwm_q.size() == 0) chk("pwm_q_empty", 0, 1);
        else chk("pwm_high_count", acc, pwm_q.pop_front());
        acc = 0;
      end
    end
  end

  initial begin : stimulus
    int hold;
    rst_ni = 1'b0;
    led_i  = 1'b1;
    repeat (5) @(negedge clk);
    rst_ni = 1'b1;
    repeat (90) @(negedge clk);
    led_i = 1'b0;
    repeat (90) @(negedge clk);
    led_i = 1'b1;
    for (int i = 0; i < 200 && !(m_mode == RISE && m_duty == 7); i++) @(negedge clk);
    chk("reach_level7", m_duty, 7);
    led_i = 1'b0;
    repeat (60) @(negedge clk);
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 9) == 0) begin
        rst_ni = 1'b0;
        hold = $urandom_range(1, 4);
        repeat (hold) @(negedge clk);
        rst_ni = 1'b1;
      end
      led_i = 1'($urandom_range(0, 1));
      hold  = $urandom_range(1, 80);
      repeat (hold) @(negedge clk);
    end
    led_i = 1'b1;
    repeat (100) @(negedge clk);
    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
